// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter for one shared, fixed-latency memory.
//
// A fetch requester (i_*) and a data requester (d_*) share one memory.
// Requests are sampled only in IDLE. When both are pending, the one that was
// not served last wins. An access holds the memory for LATENCY cycles (BUSY)
// and then spends one cycle in RESP, where the owner's valid pulses.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req, i_addr       fetch read request (level) and address
//   d_req, d_wr         data request (level), write flag
//   d_addr, d_wdata     data address, write data
//   mem_data_out        read data returned by the memory
//   i_grant, d_grant    requester owns the memory (BUSY and RESP)
//   i_valid, d_valid    one-cycle completion pulse (RESP)
//   rd_data             registered read data, shared by both requesters
//   mem_enable, mem_wr  memory enable / write strobe (BUSY only)
//   mem_addr            memory address (BUSY only, else 0)
//   mem_data_in         memory write data (BUSY only, else 0)
//   busy                state is not IDLE
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_data_out,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_valid,
  output logic        d_valid,
  output logic [15:0] rd_data,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        sel_d;      // current owner: 1 = data side, 0 = fetch side
  logic        last_d;     // last served requester: 1 = data side
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        take_i, take_d;

  // Next-state and selection
  always_comb begin
    state_nxt = state;
    take_i    = 1'b0;
    take_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          // Alternate when both are pending
          take_d = ~last_d;
          take_i = last_d;
        end else begin
          take_i = i_req;
          take_d = d_req;
        end
        if (take_i || take_d) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and captured access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      sel_d   <= 1'b0;
      last_d  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rd_data <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (take_i || take_d) begin
            sel_d   <= take_d;
            last_d  <= take_d;
            addr_q  <= take_d ? d_addr : i_addr;
            wr_q    <= take_d & d_wr;
            wdata_q <= take_d ? d_wdata : 16'd0;
            cnt     <= LAT_CNT;
          end
        end
        BUSY: begin
          // Final BUSY edge: stop the counter and capture read data
          if (cnt == 4'd1) begin
            cnt <= 4'd0;
            if (!wr_q) rd_data <= mem_data_out;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state; memory bus is zero outside BUSY
  always_comb begin
    busy        = (state != IDLE);
    i_grant     = busy & ~sel_d;
    d_grant     = busy & sel_d;
    i_valid     = (state == RESP) & ~sel_d;
    d_valid     = (state == RESP) & sel_d;
    mem_enable  = (state == BUSY);
    mem_wr      = mem_enable & wr_q;
    mem_addr    = mem_enable ? addr_q : 16'd0;
    mem_data_in = mem_enable ? wdata_q : 16'd0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 4, memory cycles per access, legal range 2..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  fetch-side read request; level, held by requester until i_valid.
REQ-005 i_addr  input  16  fetch address.
REQ-006 d_req  input  1  data-side request; level, held until d_valid.
REQ-007 d_wr  input  1  data-side access is a write when 1.
REQ-008 d_addr  input  16  data address.
REQ-009 d_wdata  input  16  data-side write data.
REQ-010 mem_data_out  input  16  read data from the shared memory.
REQ-011 i_grant, d_grant  output  1 each  requester owns the memory in the current cycle.
REQ-012 i_valid, d_valid  output  1 each  one-cycle completion pulse.
REQ-013 rd_data  output  16  registered read data, shared by both requesters.
REQ-014 mem_enable, mem_wr  output  1 each  memory enable / write strobe.
REQ-015 mem_addr, mem_data_in  output  16 each  memory address / write data.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 States: IDLE, BUSY, RESP.
REQ-018 IDLE with neither request: remain IDLE, memory outputs 0.
REQ-019 IDLE with exactly one request: that requester is selected at the next edge.
REQ-020 IDLE with both requests: select D if last_served = I, otherwise I.
REQ-021 last_served updates on entry to BUSY.
REQ-022 On selection edge, register address, write flag (d_wr for D, 0 for I) and write data.
REQ-023 On the same edge, load the counter with LATENCY and enter BUSY.
REQ-024 In BUSY, drive the registered values:
- mem_enable = 1.
- mem_wr = registered write flag.
- mem_addr and mem_data_in held stable.
REQ-025 In BUSY, decrement the counter each edge.
REQ-026 When the counter reads 1 at an edge, go to RESP.
REQ-027 For a read, that edge also loads rd_data from mem_data_out.
REQ-028 BUSY lasts exactly LATENCY cycles.
REQ-029 In RESP:
- assert the selected requester's valid for exactly one cycle.
- memory outputs return to 0.
- next state is IDLE.
REQ-030 Grant of the selected requester is high throughout BUSY and RESP; the other grant is 0.
REQ-031 Writes pulse d_valid and leave rd_data unchanged.
REQ-032 rd_data holds its value until the next read completes.
REQ-033 Request sampling: requests are sampled only in IDLE.
REQ-034 Request changes during BUSY/RESP are ignored.
REQ-035 Throughput: at most one access per LATENCY+2 cycles.
REQ-036 Latency: request seen at edge N gives valid high from edge N+1+LATENCY for one cycle.
REQ-037 Address and data are never modified during BUSY.
REQ-038 Counter is 4 bits and never wraps: it stops at the RESP transition.

Reset
REQ-039 rst_n low at any time (including mid-BUSY): immediately force the following, without waiting for clk:
- state IDLE, counter 0, last_served = I.
- all grants, valids, mem_enable, mem_wr and busy = 0.
- rd_data, mem_addr and mem_data_in = 0.
REQ-040 An access aborted by reset produces no valid pulse.
REQ-041 After release, the first edge with a request behaves per REQ-019/REQ-020.

Verification (LATENCY=4)
REQ-042 i_req=1, i_addr=0x0010 at edge 0, mem_data_out=0xBEEF:
- mem_enable=1, mem_addr=0x0010 for 4 cycles.
- rd_data=0xBEEF and i_valid=1 for one cycle from edge 5.
- idle at edge 6.
REQ-043 i_req and d_req both high after reset:
- D is served first (last_served=I).
- I is granted on the sampling edge after D's RESP.
- d_grant and i_grant are never high together.
REQ-044 d_req=1, d_wr=1, d_addr=0x0040, d_wdata=0x1234:
- mem_wr=1, mem_data_in=0x1234 for 4 cycles.
- d_valid pulses once.
- rd_data unchanged from its prior value.
REQ-045 Both requests held continuously for 30 cycles: grants alternate D, I, D, I, with one completion per 6 cycles.
REQ-046 rst_n pulsed low during BUSY cycle 2:
- all outputs are 0 asynchronously.
- no valid pulse occurs.
- a new i_req after release completes normally with the REQ-036 latency.
REQ-047 i_addr changed during BUSY: mem_addr stays at the value captured on the selection edge.
